// File: rtl/parameterized_assoc_cache_controller.sv
// Two-way set-associative write-back/write-allocate cache controller.
// Each way is a storage slice; the top holds the FSM, per-set LRU bits and the memory handshake.

module assoc_cache_way #(
    parameter int INDEX_BITS = 4,
    parameter int TAG_W      = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rsta,
    input  logic [INDEX_BITS-1:0] idx,
    input  logic                  we,
    input  logic [TAG_W-1:0]      wtag,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  wdirty,
    output logic                  vld,
    output logic                  dty,
    output logic [TAG_W-1:0]      tag,
    output logic [DATA_WIDTH-1:0] data
);
    localparam int SETS = 1 << INDEX_BITS;

    logic [SETS-1:0]       vld_q, dty_q;
    logic [TAG_W-1:0]      tag_q  [SETS];
    logic [DATA_WIDTH-1:0] data_q [SETS];

    always_ff @(posedge clk or negedge rsta) begin
        if (!rsta) begin
            vld_q <= '0;
            dty_q <= '0;
        end else if (we) begin
            vld_q[idx] <= 1'b1;
            dty_q[idx] <= wdirty;
        end
    end

    // Tag/data carry no reset; the valid bit gates every use of them.
    always_ff @(posedge clk) begin
        if (we) begin
            tag_q[idx]  <= wtag;
            data_q[idx] <= wdata;
        end
    end

    assign vld  = vld_q[idx];
    assign dty  = dty_q[idx];
    assign tag  = tag_q[idx];
    assign data = data_q[idx];
endmodule

module parameterized_assoc_cache_controller #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int INDEX_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rsta,
    input  logic                  req,
    input  logic                  wea,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  ready,
    output logic                  valid,
    output logic                  hit,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack
);
    localparam int TAG_W = ADDR_WIDTH - INDEX_BITS;
    localparam int SETS  = 1 << INDEX_BITS;
    localparam int WAYS  = 2;

    typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, FILL} state_t;

    state_t                state;
    logic                  c_we;
    logic [ADDR_WIDTH-1:0] c_addr;
    logic [DATA_WIDTH-1:0] c_din;
    logic                  vic;
    logic [SETS-1:0]       lru;

    logic [INDEX_BITS-1:0] c_idx;
    logic [TAG_W-1:0]      c_tag;
    assign c_idx = c_addr[INDEX_BITS-1:0];
    assign c_tag = c_addr[ADDR_WIDTH-1:INDEX_BITS];

    logic [WAYS-1:0]                 way_vld, way_dty, match, line_we;
    logic [WAYS-1:0][TAG_W-1:0]      way_tag;
    logic [WAYS-1:0][DATA_WIDTH-1:0] way_data;
    logic [DATA_WIDTH-1:0]           line_wdata;
    logic                            hit_way, victim;

    // Hit writes and fills both store the captured tag, so one write port serves both.
    genvar w;
    generate
        for (w = 0; w < WAYS; w++) begin : g_way
            assign match[w]   = way_vld[w] && (way_tag[w] == c_tag);
            assign line_we[w] = ((state == COMPARE) && c_we && match[w]) ||
                                ((state == FILL) && mem_ack && (vic == 1'(w)));
            assoc_cache_way #(
                .INDEX_BITS(INDEX_BITS),
                .TAG_W     (TAG_W),
                .DATA_WIDTH(DATA_WIDTH)
            ) u_way (
                .clk   (clk),
                .rsta  (rsta),
                .idx   (c_idx),
                .we    (line_we[w]),
                .wtag  (c_tag),
                .wdata (line_wdata),
                .wdirty(c_we),
                .vld   (way_vld[w]),
                .dty   (way_dty[w]),
                .tag   (way_tag[w]),
                .data  (way_data[w])
            );
        end
    endgenerate

    assign hit_way = match[1];

    always_comb begin
        victim = lru[c_idx];
        if (!way_vld[0])      victim = 1'b0;
        else if (!way_vld[1]) victim = 1'b1;
        line_wdata = c_din;
        if ((state == FILL) && !c_we) line_wdata = mem_rdata;
    end

    always_ff @(posedge clk or negedge rsta) begin
        if (!rsta) begin
            state     <= IDLE;
            ready     <= 1'b1;
            valid     <= 1'b0;
            hit       <= 1'b0;
            dout      <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            lru       <= '0;
            c_we      <= 1'b0;
            c_addr    <= '0;
            c_din     <= '0;
            vic       <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        c_we   <= wea;
                        c_addr <= addr;
                        c_din  <= din;
                        ready  <= 1'b0;
                        state  <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (|match) begin
                        if (!c_we) dout <= way_data[hit_way];
                        lru[c_idx] <= ~hit_way;
                        valid      <= 1'b1;
                        hit        <= 1'b1;
                        ready      <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        vic     <= victim;
                        mem_req <= 1'b1;
                        if (way_vld[victim] && way_dty[victim]) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= {way_tag[victim], c_idx};
                            mem_wdata <= way_data[victim];
                            state     <= WRITEBACK;
                        end else begin
                            mem_we   <= 1'b0;
                            mem_addr <= c_addr;
                            state    <= FILL;
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ack) begin
                        mem_we   <= 1'b0;
                        mem_addr <= c_addr;
                        state    <= FILL;
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!c_we) dout <= mem_rdata;
                        lru[c_idx] <= ~vic;
                        valid      <= 1'b1;
                        hit        <= 1'b0;
                        ready      <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
